// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One multiplier/quotient bit per cycle; start/busy/done handshake for pipeline stalls.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Mul,
   input  logic             Div,
   input  logic             Unsigned,
   input  logic             WriteHi,
   input  logic             WriteLo,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   // Handshake: Mul/Div/WriteHi/WriteLo are accepted only while busy=0 (IDLE);
   // done is a one-cycle pulse in the cycle the new hi/lo first become visible.
   state_t             state;
   logic [CW-1:0]      counter;
   logic               is_div;
   logic               psign;
   logic               rsign;
   logic               dbz;
   logic [WIDTH-1:0]   breg;
   logic [WIDTH-1:0]   q;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic               s1, s2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               fits;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   remv;

   assign busy = (state != IDLE);

   always_comb begin
      s1      = ~Unsigned & op1[WIDTH-1];
      s2      = ~Unsigned & op2[WIDTH-1];
      mag1    = s1 ? (~op1 + 1'b1) : op1;
      mag2    = s2 ? (~op2 + 1'b1) : op2;
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? breg : {WIDTH{1'b0}})};
      shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
      diff    = shifted - {1'b0, breg};
      fits    = (shifted >= {1'b0, breg});
      prod    = psign ? (~acc + 1'b1) : acc;
      quot    = psign ? (~q + 1'b1) : q;
      remv    = rsign ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         is_div  <= 1'b0;
         psign   <= 1'b0;
         rsign   <= 1'b0;
         dbz     <= 1'b0;
         breg    <= '0;
         q       <= '0;
         acc     <= '0;
         rem     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (Mul || Div) begin
                  is_div  <= ~Mul;
                  psign   <= s1 ^ s2;
                  rsign   <= s1;
                  dbz     <= ~Mul & (op2 == '0);
                  breg    <= Mul ? mag1 : mag2;
                  acc     <= {{WIDTH{1'b0}}, mag2};
                  q       <= mag1;
                  rem     <= '0;
                  counter <= CW'(WIDTH);
                  state   <= RUN;
               end else begin
                  if (WriteHi) hi <= op1;
                  if (WriteLo) lo <= op1;
               end
            end
            RUN: begin
               counter <= counter - CW'(1);
               if (is_div) begin
                  rem <= fits ? diff : shifted;
                  q   <= {q[WIDTH-2:0], fits};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
               if (counter == CW'(1)) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  // Divide by zero: remainder path already reconstructs op1; quotient forced to all ones.
                  hi <= remv;
                  lo <= dbz ? {WIDTH{1'b1}} : quot;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a WIDTH=32 and a WIDTH=8 instance share the command inputs.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Mul, Div, Unsigned, WriteHi, WriteLo;
   logic [31:0] op1, op2;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic        busy8, done8;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) u32 (
      .clk(clk), .reset(reset), .Mul(Mul), .Div(Div), .Unsigned(Unsigned),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .op1(op1), .op2(op2),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .Mul(Mul), .Div(Div), .Unsigned(Unsigned),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .op1(op1[7:0]), .op2(op2[7:0]),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after an active edge; the command is sampled at the next edge (E0).
   task automatic start(input logic m, input logic d, input logic u,
                        input logic [31:0] a, input logic [31:0] b);
      Mul = m; Div = d; Unsigned = u; op1 = a; op2 = b;
      @(posedge clk); #1;
      Mul = 1'b0; Div = 1'b0;
      op1 = 32'hA5A5_5A5A; op2 = 32'h0F0F_F0F0;
   endtask

   task automatic wait_done(input bit w8, output int lat, output int busy_cyc);
      lat = 0; busy_cyc = 0;
      while (!(w8 ? done8 : done) && lat < 60) begin
         if (w8 ? busy8 : busy) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, bc, pulses;
      reset = 1'b1; Mul = 0; Div = 0; Unsigned = 0; WriteHi = 0; WriteLo = 0;
      op1 = '0; op2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Unsigned max x max
      start(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("umul_busy_after_e0", busy, 1);
      wait_done(0, lat, bc);
      check("umul_latency", lat, 33);
      check("umul_busy_cycles", bc, 33);
      check("umul_hi", hi, 32'hFFFF_FFFE);
      check("umul_lo", lo, 32'h0000_0001);
      check("umul_busy_in_done", busy, 0);
      @(posedge clk); #1;
      check("umul_done_one_cycle", done, 0);

      start(1, 0, 0, 32'hFFFF_FFFD, 32'd5);
      wait_done(0, lat, bc);
      check("smul_hi", hi, 32'hFFFF_FFFF);
      check("smul_lo", lo, 32'hFFFF_FFF1);

      start(1, 0, 1, 32'hFFFF_FFFD, 32'd5);
      wait_done(0, lat, bc);
      check("umul2_hi", hi, 32'h0000_0004);
      check("umul2_lo", lo, 32'hFFFF_FFF1);

      start(0, 1, 0, 32'hFFFF_FFF9, 32'd2);
      wait_done(0, lat, bc);
      check("sdiv_latency", lat, 33);
      check("sdiv_lo", lo, 32'hFFFF_FFFD);
      check("sdiv_hi", hi, 32'hFFFF_FFFF);

      start(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, lat, bc);
      check("min_div_lo", lo, 32'h8000_0000);
      check("min_div_hi", hi, 32'h0000_0000);

      start(0, 1, 0, 32'h0000_1234, 32'd0);
      wait_done(0, lat, bc);
      check("dbz_s_hi", hi, 32'h0000_1234);
      check("dbz_s_lo", lo, 32'hFFFF_FFFF);
      start(0, 1, 1, 32'h0000_1234, 32'd0);
      wait_done(0, lat, bc);
      check("dbz_u_hi", hi, 32'h0000_1234);
      check("dbz_u_lo", lo, 32'hFFFF_FFFF);
      start(0, 1, 0, 32'hFFFF_FFFB, 32'd0);
      wait_done(0, lat, bc);
      check("dbz_neg_hi", hi, 32'hFFFF_FFFB);
      check("dbz_neg_lo", lo, 32'hFFFF_FFFF);

      // Direct HI/LO writes
      repeat (12) @(posedge clk);
      #1;
      op1 = 32'h0000_AAAA; WriteHi = 1'b1;
      @(posedge clk); #1;
      WriteHi = 1'b0;
      check("wrhi_hi", hi, 32'h0000_AAAA);
      check("wrhi_lo_kept", lo, 32'hFFFF_FFFF);
      check("wrhi_no_done", done, 0);
      op1 = 32'h0000_5555; WriteLo = 1'b1;
      @(posedge clk); #1;
      WriteLo = 1'b0;
      check("wrlo_lo", lo, 32'h0000_5555);
      check("wrlo_hi_kept", hi, 32'h0000_AAAA);
      op1 = 32'h1357_9BDF; WriteHi = 1'b1; WriteLo = 1'b1;
      @(posedge clk); #1;
      WriteHi = 1'b0; WriteLo = 1'b0;
      check("wrboth_hi", hi, 32'h1357_9BDF);
      check("wrboth_lo", lo, 32'h1357_9BDF);

      // Mul beats a simultaneous WriteHi
      op1 = 32'h2222_2222; WriteHi = 1'b1;
      start(1, 0, 1, 32'd3, 32'd4);
      WriteHi = 1'b0;
      wait_done(0, lat, bc);
      check("prio_lo", lo, 32'd12);
      check("prio_hi", hi, 32'd0);

      // Commands during busy are ignored
      repeat (8) @(posedge clk);
      #1;
      start(1, 0, 1, 32'd7, 32'd6);
      repeat (9) @(posedge clk);
      #1;
      WriteHi = 1'b1; Div = 1'b1; op1 = 32'hDEAD_BEEF; op2 = 32'd3;
      @(posedge clk); #1;
      WriteHi = 1'b0; Div = 1'b0;
      wait_done(0, lat, bc);
      check("hazard_latency", lat, 23);
      check("hazard_hi", hi, 32'd0);
      check("hazard_lo", lo, 32'd42);

      // Back-to-back: new Div in the done cycle
      @(posedge clk); #1;
      start(0, 1, 1, 32'd100, 32'd7);
      wait_done(0, lat, bc);
      check("b2b_first_lo", lo, 32'd14);
      check("b2b_first_hi", hi, 32'd2);
      Div = 1'b1; Unsigned = 1'b0; op1 = 32'hFFFF_FF9C; op2 = 32'd7;
      @(posedge clk); #1;
      Div = 1'b0;
      check("b2b_accepted_busy", busy, 1);
      wait_done(0, lat, bc);
      check("b2b_latency", lat, 33);
      check("b2b_lo", lo, 32'hFFFF_FFF2);
      check("b2b_hi", hi, 32'hFFFF_FFFE);

      // Reset in the middle of a multiply
      @(posedge clk); #1;
      start(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_hi", hi, 0);
      check("midreset_lo", lo, 0);
      check("midreset_busy", busy, 0);
      pulses = 0;
      repeat (40) begin
         if (done) pulses++;
         @(posedge clk); #1;
      end
      check("midreset_no_done", pulses, 0);
      check("midreset_hi_held", hi, 0);

      // WIDTH=8 instance
      start(1, 0, 1, 32'd200, 32'd200);
      wait_done(1, lat, bc);
      check("w8_umul_latency", lat, 9);
      check("w8_umul_busy_cycles", bc, 9);
      check("w8_umul_hi", hi8, 8'h9C);
      check("w8_umul_lo", lo8, 8'h40);
      @(posedge clk); #1;
      start(0, 1, 0, 32'h0000_0080, 32'h0000_00FF);
      wait_done(1, lat, bc);
      check("w8_mindiv_lo", lo8, 8'h80);
      check("w8_mindiv_hi", hi8, 8'h00);
      @(posedge clk); #1;
      start(1, 0, 0, 32'h0000_00FD, 32'd5);
      wait_done(1, lat, bc);
      check("w8_smul_hi", hi8, 8'hFF);
      check("w8_smul_lo", lo8, 8'hF1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
